md_pattern_gen: RTL and testbench
=================================

MD_PATTERN_GEN -- requirements
Module: md_pattern_gen

Interface
REQ-001 Parameter DW, 512, tdata width in bits; SHALL be a multiple of 32 and at least 32.
REQ-002 Parameter LEN_W, 16, width of the frame-length input in bits.
REQ-003 Parameter CNT_W, 32, width of the frame-count input and of the frame counter in bits.
REQ-004 Ports clk, input, 1: clock; resetn, input, 1: reset, synchronous, active-low.
REQ-005 Ports start, input, 1: begin a run; stop, input, 1: end the run at the next frame boundary.
REQ-006 Ports mode, input, 2: pattern select; seed, input, 32: initial pattern value.
REQ-007 Ports frame_beats, input, LEN_W: beats per frame; frame_count, input, CNT_W: frames per run, 0 = unlimited.
REQ-008 Ports axis_tdata, output, DW; axis_tvalid, output, 1; axis_tlast, output, 1; axis_tready, input, 1.
REQ-009 Ports busy, output, 1: run in progress; done, output, 1: one-cycle end-of-run pulse; frames_sent, output, CNT_W: frames completed.

Function
REQ-010 FSM states SHALL be IDLE and RUN only.
REQ-011 IDLE->RUN on start=1 SHALL latch mode, seed, frame_beats, frame_count; axis_tvalid=1 on the next cycle; frames_sent cleared.
REQ-012 In IDLE, start with frame_beats=0 SHALL be ignored (stay IDLE, no done).
REQ-013 start while in RUN SHALL be ignored; latched settings SHALL NOT change mid-run.
REQ-014 A beat transfers only when axis_tvalid & axis_tready; axis_tdata and axis_tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-015 axis_tvalid SHALL stay 1 for the whole RUN state (no bubbles).
REQ-016 Pattern value P is a 32-bit register, P=seed on the first beat of the run, advanced once per transferred beat, carried across frame boundaries.
REQ-017 mode 0: every byte of tdata = P[7:0]; advance P = P+1, 8-bit wrap 0xFF->0x00.
REQ-018 mode 1: 32-bit lane i = P+i; advance P = P + DW/32, modulo 2^32.
REQ-019 mode 2: every 32-bit lane = P; advance by a 32-bit Galois LFSR, taps 0x80200003; a seed of 0 SHALL be replaced by 1 at latch time.
REQ-020 mode 3: every 32-bit lane = P; P is never advanced.
REQ-021 axis_tlast SHALL be 1 on beat frame_beats of each frame, 0 otherwise; the beat counter resets to 1 after the tlast transfer.
REQ-022 frames_sent SHALL increment on each tlast transfer, saturating at all-ones.
REQ-023 RUN->IDLE on the tlast transfer when frames_sent+1 == frame_count (frame_count != 0), or when a stop is pending.
REQ-024 Stop SHALL be captured into a pending flag in RUN; it takes effect only at the next tlast transfer, so a stop on the tlast-transfer cycle itself ends the run there.
REQ-025 On RUN->IDLE, axis_tvalid SHALL be 0 on the next cycle, with done=1 for exactly that cycle.
REQ-026 busy SHALL equal (state == RUN).

Reset
REQ-027 resetn=0 SHALL force IDLE, with axis_tvalid=0, axis_tlast=0, busy=0, done=0, frames_sent=0, stop pending=0, P=0, beat counter=1.
REQ-028 Reset asserted mid-frame SHALL abort immediately, with no done pulse; axis_tdata is don't-care while tvalid=0.

Structure
REQ-029 Package md_pkg SHALL hold the mode encodings (MD_BYTE_CNT=0, MD_LANE_INC=1, MD_LFSR=2, MD_CONST=3), the LFSR tap constant and the nonzero-seed constant.
REQ-030 The LFSR next-state function SHALL be sub-module md_lfsr32 (32-bit in, 32-bit out, combinational).

Verification
REQ-031 DW=512, mode 0, seed=0xFE, frame_beats=4, frame_count=2, tready=1 -> 8 beats, bytes FE,FF,00,01,02,03,04,05; tlast on beats 4 and 8; done pulse; frames_sent=2.
REQ-032 Mode 1, seed=0, DW=512 -> beat 0 lanes 0..15, beat 1 lanes 16..31; random tready -> no data change while stalled.
REQ-033 Mode 2, seed=0 -> first beat lanes = 0x00000001, second beat = LFSR(1) per md_lfsr32.
REQ-034 frame_count=0, frame_beats=3, stop pulsed on beat 2 of frame 5 -> run ends after tlast of frame 5; frames_sent=5.
REQ-035 resetn=0 during beat 2 of a frame -> tvalid=0 next cycle, no done pulse; a subsequent start restarts from seed.
REQ-036 start with frame_beats=0 -> stays IDLE, tvalid never 1; start asserted during RUN -> no effect.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants for the pattern generator: mode encodings and LFSR setup.
package md_pkg;

    localparam logic [1:0] MD_BYTE_CNT = 2'd0;
    localparam logic [1:0] MD_LANE_INC = 2'd1;
    localparam logic [1:0] MD_LFSR     = 2'd2;
    localparam logic [1:0] MD_CONST    = 2'd3;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] MD_LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] MD_LFSR_NZ_SEED = 32'h0000_0001;

    // The LFSR locks up at zero, so a zero seed is swapped for a nonzero one
    function automatic logic [31:0] md_fix_seed(input logic [1:0] mode,
                                                input logic [31:0] seed);
        return (mode == MD_LFSR && seed == 32'h0) ? MD_LFSR_NZ_SEED : seed;
    endfunction

endpackage

// File: rtl/md_lfsr32.sv
// One step of the 32-bit Galois LFSR (shift right, xor taps when bit 0 falls out).
module md_lfsr32
    import md_pkg::*;
(
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    assign nxt = {1'b0, cur[31:1]} ^ (cur[0] ? MD_LFSR_TAPS : 32'h0);

endmodule

// File: rtl/md_pattern_gen.sv
// AXI-Stream test pattern generator: framed runs of byte-count, lane-increment,
// LFSR or constant data, with frame counting and a deferred stop.
module md_pattern_gen
    import md_pkg::*;
#(
    parameter int DW    = 512,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [31:0]      seed,
    input  logic [LEN_W-1:0] frame_beats,
    input  logic [CNT_W-1:0] frame_count,
    output logic [DW-1:0]    axis_tdata,
    output logic             axis_tvalid,
    output logic             axis_tlast,
    input  logic             axis_tready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int NUM_LANES = DW / 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      p_q;
    logic [31:0]      p_nxt;
    logic [31:0]      lfsr_nxt;
    logic             stop_pend;
    logic             xfer;
    logic             run_end;

    logic [NUM_LANES-1:0][31:0] lane_data;

    md_lfsr32 u_lfsr (
        .cur (p_q),
        .nxt (lfsr_nxt)
    );

    // tvalid is tied to the RUN state so the stream never bubbles mid-run
    assign busy        = (state == ST_RUN);
    assign axis_tvalid = busy;
    assign axis_tlast  = busy && (beat_q == len_q);
    assign xfer        = axis_tvalid & axis_tready;

    // A stop arriving on the tlast-transfer cycle counts as already pending
    assign run_end = xfer && axis_tlast &&
                     (stop_pend || stop ||
                      (cnt_q != '0 && (frames_sent + CNT_W'(1)) == cnt_q));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_data[i] = (mode_q == MD_BYTE_CNT) ? {4{p_q[7:0]}} :
                              (mode_q == MD_LANE_INC) ? p_q + 32'(i) : p_q;
    end

    assign axis_tdata = lane_data;

    // Pattern advance for the beat currently on the bus
    always_comb begin
        p_nxt = p_q;
        case (mode_q)
            MD_BYTE_CNT: p_nxt = {p_q[31:8], p_q[7:0] + 8'd1};
            MD_LANE_INC: p_nxt = p_q + 32'(NUM_LANES);
            MD_LFSR:     p_nxt = lfsr_nxt;
            default:     p_nxt = p_q;
        endcase
    end

    // Run control, settings latch, beat/frame counters and pattern register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            mode_q      <= MD_BYTE_CNT;
            len_q       <= '0;
            cnt_q       <= '0;
            beat_q      <= LEN_W'(1);
            p_q         <= '0;
            stop_pend   <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && frame_beats != '0) begin
                        state       <= ST_RUN;
                        mode_q      <= mode;
                        len_q       <= frame_beats;
                        cnt_q       <= frame_count;
                        p_q         <= md_fix_seed(mode, seed);
                        beat_q      <= LEN_W'(1);
                        stop_pend   <= 1'b0;
                        frames_sent <= '0;
                    end
                end
                default: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (xfer) begin
                        p_q <= p_nxt;
                        if (axis_tlast) begin
                            beat_q <= LEN_W'(1);
                            if (frames_sent != '1)
                                frames_sent <= frames_sent + CNT_W'(1);
                            if (run_end) begin
                                state     <= ST_IDLE;
                                done      <= 1'b1;
                                stop_pend <= 1'b0;
                            end
                        end else begin
                            beat_q <= beat_q + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_pattern_gen.sv
// Scoreboard bench for md_pattern_gen: expected beats are queued at start,
// a negedge monitor pops and compares each transferred beat.
module tb_md_pattern_gen;

    localparam int DW    = 512;
    localparam int LEN_W = 16;
    localparam int CNT_W = 32;
    localparam int NL    = DW / 32;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [31:0]      seed = 32'h0;
    logic [LEN_W-1:0] frame_beats = '0;
    logic [CNT_W-1:0] frame_count = '0;
    logic [DW-1:0]    axis_tdata;
    logic             axis_tvalid;
    logic             axis_tlast;
    logic             axis_tready = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;
    int   popped = 0;
    int   done_cnt = 0;
    bit   tv_seen = 1'b0;
    int   rdy_mode = 0;   // 0: low, 1: high, 2: random

    md_pattern_gen #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .seed        (seed),
        .frame_beats (frame_beats),
        .frame_count (frame_count),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tlast  (axis_tlast),
        .axis_tready (axis_tready),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // tready driver
    initial forever begin
        @(posedge clk);
        #2;
        axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    // Monitor: scoreboard pops on transfer, stall stability check otherwise
    initial begin
        logic [DW-1:0] hold_d;
        logic          hold_l;
        bit            hold_v;
        exp_t          e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (done) done_cnt++;
                if (axis_tvalid) tv_seen = 1'b1;
                if (axis_tvalid && hold_v) begin
                    vecs++;
                    if (axis_tdata !== hold_d || axis_tlast !== hold_l) begin
                        errs++;
                        $display("FAIL stall_hold: got %h/%b expected %h/%b",
                                 axis_tdata, axis_tlast, hold_d, hold_l);
                    end
                end
                hold_v = 1'b0;
                if (axis_tvalid && axis_tready) begin
                    vecs++;
                    popped++;
                    if (sbq.size() == 0) begin
                        errs++;
                        $display("FAIL beat_extra: got unexpected beat %h expected none", axis_tdata);
                    end else begin
                        e = sbq.pop_front();
                        if (axis_tdata !== e.d || axis_tlast !== e.l) begin
                            errs++;
                            $display("FAIL beat_data: got %h/%b expected %h/%b",
                                     axis_tdata, axis_tlast, e.d, e.l);
                        end
                    end
                end else if (axis_tvalid) begin
                    hold_v = 1'b1;
                    hold_d = axis_tdata;
                    hold_l = axis_tlast;
                end
            end
        end
    end

    function automatic logic [DW-1:0] mdl_data(input logic [1:0] m, input logic [31:0] p);
        logic [DW-1:0] d;
        d = '0;
        if (m == 2'd0) begin
            for (int b = 0; b < DW / 8; b++) d[8*b +: 8] = p[7:0];
        end else begin
            for (int i = 0; i < NL; i++) d[32*i +: 32] = (m == 2'd1) ? p + 32'(i) : p;
        end
        return d;
    endfunction

    function automatic logic [31:0] mdl_adv(input logic [1:0] m, input logic [31:0] p);
        case (m)
            2'd0:    return {p[31:8], p[7:0] + 8'd1};
            2'd1:    return p + 32'(NL);
            2'd2:    return p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
            default: return p;
        endcase
    endfunction

    task automatic push_run(input logic [1:0] m, input logic [31:0] s,
                            input int beats, input int n);
        logic [31:0] p;
        exp_t e;
        p = (m == 2'd2 && s == 32'h0) ? 32'h1 : s;
        for (int b = 0; b < n; b++) begin
            e.d = mdl_data(m, p);
            e.l = ((b % beats) == beats - 1);
            sbq.push_back(e);
            p = mdl_adv(m, p);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] s,
                             input int beats, input int count);
        @(posedge clk);
        #1;
        mode = m;
        seed = s;
        frame_beats = LEN_W'(beats);
        frame_count = CNT_W'(count);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_popped(input int n, input int budget);
        int b;
        b = budget;
        while (popped < n && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        vecs++;
        if (popped != n) begin
            errs++;
            $display("FAIL wait_popped: got %0d beats expected %0d", popped, n);
        end
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_frames);
        int b;
        b = budget;
        while (done !== 1'b1 && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        vecs++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL %s_done_timeout: got done=%b expected 1", name, done);
        end else begin
            vecs += 2;
            if (axis_tvalid !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL %s_idle: got tvalid=%b busy=%b expected 0/0", name, axis_tvalid, busy);
            end
            if (frames_sent !== CNT_W'(exp_frames)) begin
                errs++;
                $display("FAIL %s_frames: got %0d expected %0d", name, frames_sent, exp_frames);
            end
            @(posedge clk);
            #1;
            vecs++;
            if (done !== 1'b0) begin
                errs++;
                $display("FAIL %s_done_width: got done=%b expected 0", name, done);
            end
        end
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL %s_leftover: got %0d beats pending expected 0", name, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (axis_tvalid !== 1'b0 || axis_tlast !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || frames_sent !== '0) begin
            errs++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b f=%0d expected all 0",
                     axis_tvalid, axis_tlast, busy, done, frames_sent);
        end
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (busy !== 1'b0 || axis_tvalid !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: got busy=%b tvalid=%b expected 0/0", busy, axis_tvalid);
        end
    endtask

    task automatic test_byte_cnt;
        rdy_mode = 1;
        push_run(2'd0, 32'hFE, 4, 8);
        start_run(2'd0, 32'hFE, 4, 2);
        wait_done("byte_cnt", 100, 2);
    endtask

    task automatic test_lane_inc;
        rdy_mode = 2;
        push_run(2'd1, 32'h0, 5, 10);
        start_run(2'd1, 32'h0, 5, 2);
        wait_done("lane_inc", 400, 2);
    endtask

    task automatic test_lfsr;
        rdy_mode = 2;
        push_run(2'd2, 32'h0, 2, 6);
        start_run(2'd2, 32'h0, 2, 3);
        wait_done("lfsr", 400, 3);
    endtask

    task automatic test_const;
        rdy_mode = 2;
        push_run(2'd3, 32'hA5A5_1234, 3, 3);
        start_run(2'd3, 32'hA5A5_1234, 3, 1);
        wait_done("const", 200, 1);
    endtask

    task automatic test_stop(input int beats, input int stop_after, input int exp_frames);
        rdy_mode = 1;
        popped = 0;
        push_run(2'd0, 32'h7, beats, beats * exp_frames);
        start_run(2'd0, 32'h7, beats, 0);
        wait_popped(stop_after, 200);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done("stop", 100, exp_frames);
    endtask

    task automatic test_reset_mid;
        int d0;
        rdy_mode = 1;
        popped = 0;
        push_run(2'd0, 32'h10, 4, 1);
        start_run(2'd0, 32'h10, 4, 0);
        wait_popped(1, 50);
        d0 = done_cnt;
        resetn = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        vecs++;
        if (axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frames_sent !== '0) begin
            errs++;
            $display("FAIL reset_mid: got v=%b b=%b d=%b f=%0d expected 0/0/0/0",
                     axis_tvalid, busy, done, frames_sent);
        end
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (done_cnt != d0 || axis_tvalid !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_done: got pulses=%0d tvalid=%b expected %0d/0",
                     done_cnt - d0, axis_tvalid, 0);
        end
        sbq.delete();
        rdy_mode = 1;
        push_run(2'd0, 32'h10, 4, 4);
        start_run(2'd0, 32'h10, 4, 1);
        wait_done("restart", 50, 1);
    endtask

    task automatic test_ignore;
        int d0;
        rdy_mode = 1;
        d0 = done_cnt;
        tv_seen = 1'b0;
        start_run(2'd0, 32'h1, 0, 1);
        repeat (5) @(posedge clk);
        #1;
        vecs++;
        if (busy !== 1'b0 || tv_seen || done_cnt != d0) begin
            errs++;
            $display("FAIL zero_len: got busy=%b tvalid_seen=%b pulses=%0d expected 0/0/0",
                     busy, tv_seen, done_cnt - d0);
        end
        rdy_mode = 0;
        push_run(2'd3, 32'hCAFE_0001, 2, 4);
        start_run(2'd3, 32'hCAFE_0001, 2, 2);
        start_run(2'd0, 32'h0, 7, 0);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL start_in_run: got busy=%b expected 1", busy);
        end
        rdy_mode = 2;
        wait_done("start_in_run", 200, 2);
    endtask

    initial begin
        test_reset();
        test_byte_cnt();
        test_lane_inc();
        test_lfsr();
        test_const();
        test_stop(3, 13, 5);
        test_stop(2, 3, 2);
        test_reset_mid();
        test_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
